// File: rtl/fetch_prefetch.sv
// fetch_prefetch: AXI4 single-beat instruction prefetcher with a DEPTH-entry word queue
// and static predict-taken predecode of returned words.
module fetch_prefetch #(
    parameter int          ADDR_W   = 18,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_pred,
    output logic              out_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    output logic [3:0]        arid,
    input  logic              arready,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [3:0]        arcache,
    output logic              arlock,
    output logic [2:0]        arprot,
    output logic [3:0]        arqos,
    input  logic [31:0]       rdata,
    input  logic [3:0]        rid,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc, exp_pc, target, base;
    logic [3:0]    epoch, next_epoch;
    logic [CW-1:0] outstanding, count, eff_count;
    logic [AW-1:0] head, tail;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic          q_pred  [DEPTH];
    logic          q_err   [DEPTH];
    logic          ar_hs, r_hs, enq, deq, is_j, is_bc, is_bb, pred, issue;
    logic          unused_rlast;

    assign arlen   = 8'h00;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arcache = 4'b0011;
    assign arlock  = 1'b0;
    assign arprot  = 3'b000;
    assign arqos   = 4'h0;
    assign unused_rlast = rlast;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    // A beat arriving with a redirect belongs to the flushed stream
    assign enq   = r_hs && rid == epoch && !redirect;
    assign deq   = out_valid && out_ready;

    assign is_j   = rdata[31:27] == 5'b00001;
    assign is_bc  = rdata[31:26] == 6'b110010;
    assign is_bb  = rdata[31:27] == 5'b00010 && rdata[15];
    assign target = is_j  ? {4'b0, rdata[25:0], 2'b00} :
                    is_bc ? exp_pc + {4'b0, rdata[25:0], 2'b00} :
                            exp_pc + {{14{1'b1}}, rdata[15:0], 2'b00};
    assign pred   = enq && rresp == 2'b00 && (is_j || is_bc || is_bb);

    assign base       = redirect ? redirect_pc : pred ? target : fetch_pc;
    assign next_epoch = (redirect || pred) ? epoch + 4'd1 : epoch;
    assign eff_count  = redirect ? '0 : count;
    assign issue      = !arvalid && (outstanding + eff_count) < FULL;

    assign out_valid = count != '0;
    assign out_pc    = q_pc[head];
    assign out_instr = q_instr[head];
    assign out_pred  = out_valid && q_pred[head];
    assign out_err   = out_valid && q_err[head];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= RESET_PC;
            exp_pc      <= RESET_PC;
            epoch       <= '0;
            outstanding <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            arvalid     <= 1'b0;
            araddr      <= '0;
            arid        <= '0;
            rready      <= 1'b0;
        end else begin
            rready      <= 1'b1;
            epoch       <= next_epoch;
            fetch_pc    <= issue ? base + 32'd4 : base;
            exp_pc      <= redirect ? redirect_pc : pred ? target : enq ? exp_pc + 32'd4 : exp_pc;
            outstanding <= outstanding + CW'(ar_hs) - CW'(r_hs);
            arvalid     <= ar_hs ? 1'b0 : (issue || arvalid);
            if (issue) begin
                araddr <= base[ADDR_W-1:0];
                arid   <= next_epoch;
            end
            if (redirect) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                count <= count + CW'(enq) - CW'(deq);
                head  <= deq ? head + AW'(1) : head;
                tail  <= enq ? tail + AW'(1) : tail;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail]    <= exp_pc;
            q_instr[tail] <= rdata;
            q_pred[tail]  <= pred;
            q_err[tail]   <= rresp != 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) assert (!(enq && count == FULL));
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: scoreboard bench with a reactive AXI read slave and a reference fetch-stream model.
module tb_fetch_prefetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rstn = 1'b0, redirect = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_pred, out_err, arvalid, arlock, rready;
    logic [31:0] out_pc, out_instr;
    logic [17:0] araddr;
    logic [3:0]  arid, arcache, arqos;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [31:0] rdata = '0;
    logic [3:0]  rid = '0;
    logic [1:0]  rresp = '0;

    typedef struct packed {logic [31:0] addr; logic [3:0] id; int rdy;} req_t;
    typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic pred; logic err;} exp_t;
    req_t pend[$];
    exp_t exp_q[$];
    logic [31:0] mem [1024];
    logic        mem_err [1024];
    int cyc = 0, ar_cnt = 0, max_pend = 0, delay = 1;
    logic ar_hold = 1'b0;
    int errors = 0, checks = 0;

    fetch_prefetch #(.ADDR_W(18), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_pred(out_pred), .out_err(out_err), .araddr(araddr), .arvalid(arvalid), .arid(arid),
        .arready(arready), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arcache(arcache),
        .arlock(arlock), .arprot(arprot), .arqos(arqos), .rdata(rdata), .rid(rid), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    // Slave bookkeeping on the active edge, output drive on the falling edge
    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            pend.delete();
            ar_cnt = 0;
            max_pend = 0;
        end else begin
            if (rvalid && rready) void'(pend.pop_front());
            if (arvalid && arready) begin
                pend.push_back('{32'(araddr), arid, cyc + delay});
                ar_cnt++;
            end
            if (pend.size() > max_pend) max_pend = pend.size();
        end
    end

    always @(negedge clk) begin
        arready = !ar_hold;
        rvalid = rstn && pend.size() > 0 && pend[0].rdy <= cyc;
        rlast = rvalid;
        if (rvalid) begin
            rdata = mem[pend[0].addr[11:2]];
            rid   = pend[0].id;
            rresp = mem_err[pend[0].addr[11:2]] ? 2'b10 : 2'b00;
        end
    end

    task automatic set_mem();
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'hA000_0000 | (i << 2);
            mem_err[i] = 1'b0;
        end
    endtask

    task automatic do_reset(input logic rdy);
        rstn = 1'b0;
        redirect = 1'b0;
        out_ready = rdy;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic void push_exp(input logic [31:0] start, input int n);
        logic [31:0] pc, w, nxt;
        logic p, e;
        pc = start;
        for (int k = 0; k < n; k++) begin
            w = mem[pc[11:2]];
            e = mem_err[pc[11:2]];
            p = 1'b1;
            if (!e && w[31:26] inside {6'd2, 6'd3}) nxt = {4'h0, w[25:0], 2'b00};
            else if (!e && w[31:26] == 6'd50) nxt = pc + {4'h0, w[25:0], 2'b00};
            else if (!e && w[31:26] inside {6'd4, 6'd5} && w[15]) nxt = pc + 32'($signed(w[15:0])) * 4;
            else begin
                nxt = pc + 4;
                p = 1'b0;
            end
            exp_q.push_back('{pc, w, p, e});
            pc = nxt;
        end
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        out_ready = 1'b1;
        set_mem();
        @(negedge clk);
        @(negedge clk);
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %b want 0", rready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({out_pred, out_err} !== 2'b00) begin errors++; $display("FAIL reset_pred_err got %b%b want 00", out_pred, out_err); end
        checks++; if ({araddr, arid} !== 22'h0) begin errors++; $display("FAIL reset_ar got %h/%h want 0/0", araddr, arid); end
        checks++; if ({arlen, arsize, arburst, arcache, arlock, arprot, arqos} !== {8'h0, 3'b010, 2'b01, 4'b0011, 1'b0, 3'b0, 4'h0})
            begin errors++; $display("FAIL ar_const got %h %b %b %b %b %b %h", arlen, arsize, arburst, arcache, arlock, arprot, arqos); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rready_after_reset got %b want 1", rready); end
        checks++; if ({arvalid, araddr, arid} !== {1'b1, 18'h0, 4'h0}) begin errors++; $display("FAIL first_ar got v=%b a=%h id=%h want 1/0/0", arvalid, araddr, arid); end
    endtask

    task automatic test_sequential();
        int got = 0;
        exp_t e;
        set_mem();
        delay = 1;
        do_reset(1'b1);
        push_exp(32'h0, 16);
        for (int t = 0; t < 300 && got < 16; t++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_pc, out_instr, out_pred, out_err} !== e) begin errors++; $display("FAIL seq[%0d] got pc=%h instr=%h pred=%b err=%b want pc=%h instr=%h pred=%b err=%b", got, out_pc, out_instr, out_pred, out_err, e.pc, e.instr, e.pred, e.err); end
                got++;
            end
        end
        checks++; if (got != 16) begin errors++; $display("FAIL seq_timeout got %0d words want 16", got); end
        checks++; if (max_pend > DEPTH) begin errors++; $display("FAIL seq_outstanding got %0d want <= %0d", max_pend, DEPTH); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        exp_t e;
        set_mem();
        delay = 1;
        do_reset(1'b0);
        repeat (12) @(negedge clk);
        checks++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, mem[0]}) begin errors++; $display("FAIL bp_head_early got v=%b pc=%h instr=%h want 1/0/%h", out_valid, out_pc, out_instr, mem[0]); end
        repeat (8) @(negedge clk);
        checks++; if (ar_cnt != DEPTH) begin errors++; $display("FAIL bp_ar_count got %0d want %0d", ar_cnt, DEPTH); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL bp_arvalid got %b want 0", arvalid); end
        checks++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, mem[0]}) begin errors++; $display("FAIL bp_head_stable got v=%b pc=%h instr=%h want 1/0/%h", out_valid, out_pc, out_instr, mem[0]); end
        out_ready = 1'b1;
        push_exp(32'h0, 8);
        for (int t = 0; t < 300 && got < 8; t++) begin
            if (t > 0) @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_pc, out_instr, out_pred, out_err} !== e) begin errors++; $display("FAIL bp[%0d] got pc=%h instr=%h pred=%b want pc=%h instr=%h pred=%b", got, out_pc, out_instr, out_pred, e.pc, e.instr, e.pred); end
                got++;
            end
        end
        checks++; if (got != 8) begin errors++; $display("FAIL bp_timeout got %0d words want 8", got); end
    endtask

    task automatic test_predict();
        exp_t e;
        logic [31:0] words [4] = '{32'h0800_0040, 32'h1000_FFFC, 32'h1000_0004, 32'h0800_0040};
        int          locs  [4] = '{4, 8, 8, 4};
        for (int s = 0; s < 4; s++) begin
            int got = 0;
            set_mem();
            mem[locs[s]] = words[s];
            mem_err[locs[s]] = (s == 3);
            delay = 1;
            do_reset(1'b1);
            push_exp(32'h0, 12);
            for (int t = 0; t < 300 && got < 12; t++) begin
                @(negedge clk);
                if (out_valid && out_ready) begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({out_pc, out_instr, out_pred, out_err} !== e) begin errors++; $display("FAIL pred%0d[%0d] got pc=%h instr=%h pred=%b err=%b want pc=%h instr=%h pred=%b err=%b", s, got, out_pc, out_instr, out_pred, out_err, e.pc, e.instr, e.pred, e.err); end
                    got++;
                end
            end
            checks++; if (got != 12) begin errors++; $display("FAIL pred%0d_timeout got %0d words want 12", s, got); end
        end
    endtask

    task automatic test_redirect();
        int got = 0, t = 0;
        exp_t e;
        set_mem();
        delay = 5;
        do_reset(1'b1);
        while (pend.size() < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++; if (pend.size() < 3) begin errors++; $display("FAIL redir_pending got %0d want 3", pend.size()); end
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got out_valid=%b want 0", out_valid); end
        checks++; if ({arvalid, araddr, arid} !== {1'b1, 18'h200, 4'h1}) begin errors++; $display("FAIL redir_ar got v=%b a=%h id=%h want 1/200/1", arvalid, araddr, arid); end
        push_exp(32'h200, 8);
        for (int k = 0; k < 400 && got < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_pc, out_instr, out_pred, out_err} !== e) begin errors++; $display("FAIL redir[%0d] got pc=%h instr=%h want pc=%h instr=%h", got, out_pc, out_instr, e.pc, e.instr); end
                got++;
            end
        end
        checks++; if (got != 8) begin errors++; $display("FAIL redir_timeout got %0d words want 8", got); end
        checks++; if (max_pend > DEPTH) begin errors++; $display("FAIL redir_outstanding got %0d want <= %0d", max_pend, DEPTH); end
    endtask

    task automatic test_redirect_stall();
        int got = 0, t = 0;
        exp_t e;
        set_mem();
        delay = 1;
        ar_hold = 1'b1;
        do_reset(1'b1);
        while (arvalid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({arvalid, araddr, arid} !== {1'b1, 18'h0, 4'h0}) begin errors++; $display("FAIL stall_ar[%0d] got v=%b a=%h id=%h want 1/0/0", k, arvalid, araddr, arid); end
            @(negedge clk);
        end
        ar_hold = 1'b0;
        push_exp(32'h300, 6);
        for (int k = 0; k < 300 && got < 6; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_pc, out_instr, out_pred, out_err} !== e) begin errors++; $display("FAIL stall[%0d] got pc=%h instr=%h want pc=%h instr=%h", got, out_pc, out_instr, e.pc, e.instr); end
                got++;
            end
        end
        checks++; if (got != 6) begin errors++; $display("FAIL stall_timeout got %0d words want 6", got); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_predict();
        test_redirect();
        test_redirect_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
